// File: rtl/edge_point_extract.sv
// Raster edge detector: tags edge pixels with their (col,row) and queues them in a point FIFO.
// Define EDGE_GRADIENT_EN to switch the edge test from absolute level to horizontal gradient.
module edge_point_extract #(
  parameter int COLS   = 16,
  parameter int ROWS   = 16,
  parameter int THRESH = 128,
  parameter int DEPTH  = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] pixel_i,
  input  logic       frame_i,
  input  logic       line_i,
  output logic [7:0] point_x_o,
  output logic [7:0] point_y_o,
  output logic       point_valid_o,
  input  logic       point_ready_i,
  output logic       overflow_o,
  output logic       frame_done_o
);

  localparam int             AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [7:0]     COL_MAX = 8'(COLS - 1);
  localparam logic [7:0]     ROW_MAX = 8'(ROWS - 1);
  localparam logic [7:0]     THR     = 8'(THRESH);
  localparam logic [AW:0]    FULL    = (AW + 1)'(DEPTH);
  localparam logic [AW:0]    CNT_ONE = (AW + 1)'(1);
  localparam logic [AW-1:0]  PTR_ONE = AW'(1);

  typedef enum logic {UNSYNC, ACTIVE} state_e;

  state_e      state_q, state_d;
  logic [7:0]  col_q, col_d;
  logic [7:0]  row_q, row_d;
  logic        past_end_q, past_end_d;
  logic        take;
  logic        last_d;
  logic        is_edge;

  // Pixel stage: registered push request and end-of-frame marker; coordinates live in col_q/row_q.
  logic        push_q;
  logic        last_q;
  logic        frame_done_q;
  logic        overflow_q;

  logic [15:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q, count_d;
  logic          pop, push_en;
  logic [15:0]   head;

`ifdef EDGE_GRADIENT_EN
  logic [7:0] prev_q;
  logic [7:0] diff;

  always_comb begin
    diff    = (pixel_i >= prev_q) ? (pixel_i - prev_q) : (prev_q - pixel_i);
    is_edge = !line_i && (diff >= THR);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) prev_q <= 8'd0;
    else     prev_q <= pixel_i;
  end
`else
  assign is_edge = (pixel_i >= THR);
`endif

  // NOTE: every signal assigned here gets a default first so no latch is inferred.
  always_comb begin
    state_d    = state_q;
    col_d      = col_q;
    row_d      = row_q;
    past_end_d = past_end_q;
    take       = 1'b0;
    if (state_q == UNSYNC && frame_i) state_d = ACTIVE;
    if (state_q == ACTIVE || frame_i) begin
      if (frame_i) begin
        col_d      = 8'd0;
        row_d      = 8'd0;
        past_end_d = 1'b0;
        take       = 1'b1;
      end else if (line_i) begin
        col_d = 8'd0;
        if (row_q == ROW_MAX) begin
          past_end_d = 1'b1;
        end else begin
          row_d = row_q + 8'd1;
          take  = 1'b1;
        end
      end else if (col_q != COL_MAX) begin
        col_d = col_q + 8'd1;
        take  = !past_end_q;
      end
    end
    last_d = take && (col_d == COL_MAX) && (row_d == ROW_MAX);
  end

  assign pop     = (count_q != '0) && point_ready_i;
  assign push_en = push_q && ((count_q != FULL) || pop);

  always_comb begin
    count_d = count_q;
    if (push_en && !pop)      count_d = count_q + CNT_ONE;
    else if (!push_en && pop) count_d = count_q - CNT_ONE;
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= UNSYNC;
      col_q        <= 8'd0;
      row_q        <= 8'd0;
      past_end_q   <= 1'b0;
      push_q       <= 1'b0;
      last_q       <= 1'b0;
      frame_done_q <= 1'b0;
      overflow_q   <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      row_q        <= row_d;
      past_end_q   <= past_end_d;
      push_q       <= take && is_edge;
      last_q       <= last_d;
      frame_done_q <= last_q;
      if (push_q && (count_q == FULL) && !pop) overflow_q <= 1'b1;
      if (push_en) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop)     rd_ptr_q <= rd_ptr_q + PTR_ONE;
      count_q      <= count_d;
    end
  end

  // NOTE: FIFO storage is deliberately not reset; the count gates every read of it.
  always_ff @(posedge clk) begin
    if (push_en) mem[wr_ptr_q] <= {col_q, row_q};
  end

  assign head          = mem[rd_ptr_q];
  assign point_valid_o = (count_q != '0);
  assign point_x_o     = point_valid_o ? head[15:8] : 8'd0;
  assign point_y_o     = point_valid_o ? head[7:0]  : 8'd0;
  assign overflow_o    = overflow_q;
  assign frame_done_o  = frame_done_q;

endmodule

// File: tb/tb_edge_point_extract.sv
// Directed bench for edge_point_extract on a 4x4 frame with an 8-entry point FIFO.
module tb_edge_point_extract;

  localparam int COLS  = 4;
  localparam int ROWS  = 4;
  localparam int DEPTH = 8;
`ifdef EDGE_GRADIENT_EN
  localparam int TH = 50;
`else
  localparam int TH = 128;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] pixel_i;
  logic       frame_i;
  logic       line_i;
  logic [7:0] point_x_o;
  logic [7:0] point_y_o;
  logic       point_valid_o;
  logic       point_ready_i;
  logic       overflow_o;
  logic       frame_done_o;

  int checks   = 0;
  int failures = 0;

  edge_point_extract #(.COLS(COLS), .ROWS(ROWS), .THRESH(TH), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .pixel_i      (pixel_i),
    .frame_i      (frame_i),
    .line_i       (line_i),
    .point_x_o    (point_x_o),
    .point_y_o    (point_y_o),
    .point_valid_o(point_valid_o),
    .point_ready_i(point_ready_i),
    .overflow_o   (overflow_o),
    .frame_done_o (frame_done_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive one pixel, let it be sampled, then settle just after the edge.
  task automatic send(input logic [7:0] p, input logic f, input logic l);
    pixel_i = p;
    frame_i = f;
    line_i  = l;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    pixel_i = 8'd0;
    frame_i = 1'b0;
    line_i = 1'b0;
    point_ready_i = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Head as {valid, x, y}; expected value for raster index idx of a 4-wide frame.
  function automatic logic [31:0] obs_head();
    return {15'd0, point_valid_o, point_x_o, point_y_o};
  endfunction

  function automatic logic [31:0] exp_head(input int idx);
    return {15'd0, 1'b1, 8'(idx % COLS), 8'(idx / COLS)};
  endfunction

  initial begin
    rst = 1'b1;
    pixel_i = 8'd0;
    frame_i = 1'b0;
    line_i = 1'b0;
    point_ready_i = 1'b0;
    #3;
    check("rst_valid", 32'(point_valid_o), 32'd0);
    check("rst_x", 32'(point_x_o), 32'd0);
    check("rst_y", 32'(point_y_o), 32'd0);
    check("rst_ovf", 32'(overflow_o), 32'd0);
    check("rst_done", 32'(frame_done_o), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

`ifdef EDGE_GRADIENT_EN
    begin
      logic [7:0] g [12];
      g = '{8'd10, 8'd10, 8'd70, 8'd75, 8'd0, 8'd0, 8'd0, 8'd0,
            8'd255, 8'd255, 8'd255, 8'd255};
      point_ready_i = 1'b1;
      for (int n = 0; n < 14; n++) begin
        if (n < 12) send(g[n], n == 0, (n % COLS) == 0);
        else        send(8'd0, 1'b0, 1'b0);
        check("grad_valid", 32'(point_valid_o), 32'(n == 3));
        if (n == 3) check("grad_pt", obs_head(), exp_head(2));
      end
    end
`else
    // Single edge pixel 200 at (2,1), consumer always ready.
    point_ready_i = 1'b1;
    for (int n = 0; n < 18; n++) begin
      if (n < 16) send((n == 6) ? 8'd200 : 8'd0, n == 0, (n % COLS) == 0);
      else        send(8'd0, 1'b0, 1'b0);
      check("one_valid", 32'(point_valid_o), 32'(n == 7));
      check("one_done", 32'(frame_done_o), 32'(n == 16));
      if (n == 7) check("one_pt", obs_head(), exp_head(6));
    end

    // Pixels before the first Frame are ignored; then every pixel is an edge.
    do_reset();
    point_ready_i = 1'b1;
    for (int n = 0; n < 6; n++) begin
      send(8'd255, 1'b0, (n % COLS) == 0);
      check("unsync_valid", 32'(point_valid_o), 32'd0);
    end
    for (int n = 0; n < 18; n++) begin
      if (n < 16) send(8'd255, n == 0, (n % COLS) == 0);
      else        send(8'd0, 1'b0, 1'b0);
      if (n == 0)       check("raster_first", 32'(point_valid_o), 32'd0);
      else if (n <= 16) check("raster_pt", obs_head(), exp_head(n - 1));
      else              check("raster_empty", 32'(point_valid_o), 32'd0);
      check("raster_done", 32'(frame_done_o), 32'(n == 16));
    end

    // Ten edge pixels into an 8-deep FIFO with no consumer.
    do_reset();
    for (int n = 0; n < 16; n++) begin
      send((n < 10) ? 8'd255 : 8'd0, n == 0, (n % COLS) == 0);
      if (n == 8) check("ovf_before", 32'(overflow_o), 32'd0);
      if (n == 9) check("ovf_set", 32'(overflow_o), 32'd1);
    end
    point_ready_i = 1'b1;
    for (int j = 0; j < DEPTH; j++) begin
      check("ovf_drain", obs_head(), exp_head(j));
      send(8'd0, 1'b0, 1'b0);
    end
    check("ovf_empty", 32'(point_valid_o), 32'd0);
    check("ovf_sticky", 32'(overflow_o), 32'd1);

    // Full FIFO with simultaneous push and pop every cycle.
    do_reset();
    for (int n = 0; n < 25; n++) begin
      point_ready_i = (n >= 9);
      if (n < 16) send(8'd255, n == 0, (n % COLS) == 0);
      else        send(8'd0, 1'b0, 1'b0);
      if (n >= 9 && n <= 23) check("full_pp_pt", obs_head(), exp_head(n - 8));
      if (n == 24)           check("full_pp_empty", 32'(point_valid_o), 32'd0);
      check("full_pp_ovf", 32'(overflow_o), 32'd0);
    end

    // Reset pulse mid-frame with three entries queued.
    do_reset();
    for (int n = 0; n < 5; n++) send((n < 3) ? 8'd255 : 8'd0, n == 0, n == 0);
    check("mid_rst_pre", obs_head(), exp_head(0));
    #2 rst = 1'b1;
    #1 check("mid_rst_now", 32'(point_valid_o), 32'd0);
    #1 rst = 1'b0;
    send(8'd255, 1'b0, 1'b0);
    check("mid_rst_next", 32'(point_valid_o), 32'd0);
    for (int n = 0; n < 8; n++) begin
      send(8'd255, 1'b0, (n % COLS) == 0);
      check("mid_rst_unsync", 32'(point_valid_o), 32'd0);
    end
    send(8'd255, 1'b1, 1'b1);
    check("resync_lat", 32'(point_valid_o), 32'd0);
    send(8'd255, 1'b0, 1'b0);
    check("resync_pt", obs_head(), exp_head(0));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/edge_point_extract.md
EDGE_POINT_EXTRACT -- requirements
Module: edge_point_extract

Interface
REQ-001 Parameter COLS, default 16: pixels per line, range 2..256.
REQ-002 Parameter ROWS, default 16: lines per frame, range 2..256.
REQ-003 Parameter THRESH, default 128: 8-bit edge threshold.
REQ-004 Parameter DEPTH, default 8: point FIFO entries, power of two, range 2..64.
REQ-005 Clk  input  1  single clock; all state on rising edge.
REQ-006 Reset  input  1  asynchronous, active-high reset.
REQ-007 Pixel  input  8  upstream pixel, one per cycle, never stalls.
REQ-008 Frame  input  1  high with first pixel of a frame; Line is also high that cycle.
REQ-009 Line  input  1  high with first pixel of each line.
REQ-010 PointX  output  8  column of head FIFO entry.
REQ-011 PointY  output  8  row of head FIFO entry.
REQ-012 PointValid  output  1  FIFO non-empty; PointX/PointY valid.
REQ-013 PointReady  input  1  consumer accepts head entry when PointValid && PointReady.
REQ-014 Overflow  output  1  sticky: an edge point was dropped.
REQ-015 FrameDone  output  1  one-cycle pulse: last pixel of frame processed.

Function
REQ-016 Two states: UNSYNC (after reset) and ACTIVE; Frame sampled high moves UNSYNC->ACTIVE; no other exit.
REQ-017 UNSYNC: pixels discarded, no pushes, FrameDone low.
REQ-018 Counters col/row, 8 bits: Frame -> col=0,row=0; Line only -> col=0,row+1; neither -> col+1; current pixel takes the updated values.
REQ-019 col saturates at COLS-1, row at ROWS-1; a pixel arriving past saturation (missing Line/Frame) is discarded.
REQ-020 Edge test (default): Pixel >= THRESH, unsigned 8-bit compare.
REQ-021 Edge pixel in ACTIVE pushes {col,row} into FIFO; latency: pixel sampled at edge k -> PointValid high after edge k+1 when FIFO empty.
REQ-022 FIFO is first-in first-out; pop on PointValid && PointReady; PointX/PointY stable while PointValid && !PointReady.
REQ-023 Push while full and no pop same cycle: entry dropped, Overflow set to 1, FIFO contents unchanged.
REQ-024 Push and pop same cycle while full: both succeed, no drop, occupancy unchanged.
REQ-025 Push and pop same cycle while occupancy 1: both succeed; new entry at head next cycle.
REQ-026 PointReady while empty: no effect.
REQ-027 FrameDone pulses for exactly one cycle after edge k+1 when pixel at col=COLS-1,row=ROWS-1 sampled at edge k.
REQ-028 Frame arriving mid-frame restarts counters at 0,0; FIFO contents preserved; no FrameDone for the truncated frame.

Reset
REQ-029 Reset high: state UNSYNC, col=0, row=0, FIFO empty, PointValid=0, PointX=0, PointY=0, Overflow=0, FrameDone=0, gradient register=0.
REQ-030 Reset asserted mid-frame takes effect immediately; pending entries lost; resync requires next Frame.
REQ-031 Overflow clears only on Reset.

Configuration
REQ-032 Macro EDGE_GRADIENT_EN defined: edge test becomes |Pixel - prev| >= THRESH, prev = previous pixel of same line; first pixel of every line (Line high) is never an edge; latency unchanged.
REQ-033 Macro EDGE_GRADIENT_EN undefined: absolute test of REQ-020; no prev register.

Verification
REQ-034 COLS=ROWS=4, THRESH=128, Reset, Frame, pixel 200 at (2,1), rest 0, PointReady=1 -> one point X=2,Y=1, PointValid one cycle, FrameDone once after pixel 15.
REQ-035 Pixels before first Frame all 255 -> no PointValid until Frame; after Frame all 16 pixels pushed in raster order (0,0)..(3,3).
REQ-036 DEPTH=8, PointReady=0, 10 edge pixels -> 8 entries held, Overflow=1, first pop gives first pushed coordinate.
REQ-037 FIFO full, PointReady=1, edge pixel every cycle -> no drop, Overflow stays 0, occupancy stays 8.
REQ-038 EDGE_GRADIENT_EN, THRESH=50, line 10,10,70,75 -> single point at col 2; Line pixel 255 after 0 -> no point.
REQ-039 Reset pulse mid-frame with 3 entries queued -> PointValid=0 next cycle; no points until next Frame.
